dff_reset: RTL and testbench



---
 rtl/dff_pkg.sv | 21 ++
 rtl/dff_bit.sv | 20 ++
 rtl/dff_reset.sv | 34 +++
 tb/tb_dff_reset.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_reset register family.
package dff_pkg;

   localparam int unsigned DFF_DEFAULT_WIDTH = 32'd1;
   localparam int unsigned DFF_MAX_WIDTH     = 32'd64;

   // Builds a reset vector with the low 'width' bits all set to 'ones'; upper bits stay zero.
   function automatic logic [63:0] reset_vector(input int unsigned width, input logic ones);
      logic [63:0] v;
      v = 64'd0;
      for (int unsigned i = 32'd0; i < 32'd64; i++) begin
         if (i < width) begin
            v[i] = ones;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/dff_bit.sv
// Single-bit D flop with asynchronous active-high reset to a per-bit constant.
module dff_bit #(
   parameter logic RESET_BIT = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   // Reset wins at once; otherwise capture d on every rising edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= RESET_BIT;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/dff_reset.sv
// Parameterised D register: WIDTH independent dff_bit flops, each with its own reset bit.
module dff_reset
   import dff_pkg::*;
#(
   parameter int unsigned      WIDTH       = DFF_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(reset_vector(WIDTH, 1'b0))
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (WIDTH < 32'd1) begin : g_width_too_small
      $error("dff_reset: WIDTH must be at least 1");
   end

   if (WIDTH > DFF_MAX_WIDTH) begin : g_width_too_large
      $error("dff_reset: WIDTH must not exceed 64");
   end

   // q comes straight from the flops, so there is no combinational path from d.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff_bit #(
         .RESET_BIT (RESET_VALUE[i])
      ) u_bit (
         .clk   (clk),
         .reset (reset),
         .d     (d[i]),
         .q     (q[i])
      );
   end

endmodule

// File: tb/tb_dff_reset.sv
// Directed plus randomized bench for dff_reset at WIDTH=1 (reset 0) and WIDTH=8 (reset 8'hA5).
module tb_dff_reset;

   logic       clk;
   logic       reset1;
   logic       d1;
   logic       q1;
   logic       reset8;
   logic [7:0] d8;
   logic [7:0] q8;

   int checks;
   int failures;

   localparam logic [7:0] RV8 = 8'hA5;

   dff_reset #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
      .clk   (clk),
      .reset (reset1),
      .d     (d1),
      .q     (q1)
   );

   dff_reset #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
      .clk   (clk),
      .reset (reset8),
      .d     (d8),
      .q     (q8)
   );

   // 20-unit clock, rising edges at 10, 30, 50, ...
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic wait_to(input longint t);
      #(t - longint'($time));
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] exp8;
      logic       exp1;
      logic [7:0] r8;
      logic       r1;
      longint     t0;

      checks   = 0;
      failures = 0;

      // Power-up reset with d toggling underneath.
      reset1 = 1'b1; reset8 = 1'b1; d1 = 1'b0; d8 = 8'h00;
      wait_to(5);   check("por_async_w1", {7'd0, q1}, 8'h00);
                    check("por_async_w8", q8, RV8);
      d1 = 1'b1;
      wait_to(11);  check("por_edge10", {7'd0, q1}, 8'h00);
      wait_to(15);  d1 = 1'b0;
      wait_to(25);  d1 = 1'b1;
      wait_to(31);  check("por_edge30", {7'd0, q1}, 8'h00);
      wait_to(35);  d1 = 1'b0;

      // Normal capture.
      wait_to(45);  reset1 = 1'b0; d1 = 1'b1;
      wait_to(49);  check("release_hold", {7'd0, q1}, 8'h00);
      wait_to(55);  check("cap_50", {7'd0, q1}, 8'h01);
      wait_to(60);  d1 = 1'b0;
      wait_to(75);  check("cap_70", {7'd0, q1}, 8'h00);
      wait_to(80);  d1 = 1'b1;
      wait_to(95);  check("cap_90", {7'd0, q1}, 8'h01);
      wait_to(115); check("cap_110", {7'd0, q1}, 8'h01);

      // Async reset mid-run, d held high.
      wait_to(125); reset1 = 1'b1;
      wait_to(126); check("async_125", {7'd0, q1}, 8'h00);
      wait_to(135); check("rst_edge130", {7'd0, q1}, 8'h00);
      wait_to(154); check("rst_edge150", {7'd0, q1}, 8'h00);

      // Release and resume.
      wait_to(155); reset1 = 1'b0; d1 = 1'b1;
      wait_to(169); check("resume_pre170", {7'd0, q1}, 8'h00);
      wait_to(175); check("resume_170", {7'd0, q1}, 8'h01);
      wait_to(185); d1 = 1'b0;
      wait_to(195); check("resume_190", {7'd0, q1}, 8'h00);

      // Mid-cycle glitch on d must not disturb q.
      wait_to(200); d1 = 1'b1;
      wait_to(215); check("hold_pre", {7'd0, q1}, 8'h01);
      d1 = 1'b0;
      wait_to(220); d1 = 1'b1;
      wait_to(225); check("hold_post", {7'd0, q1}, 8'h01);

      // Wide instance with non-zero reset value.
      wait_to(241); check("w8_rst", q8, RV8);
      wait_to(245); reset8 = 1'b0; d8 = 8'h3C;
      wait_to(249); check("w8_release_hold", q8, RV8);
      wait_to(251); check("w8_cap", q8, 8'h3C);
      wait_to(265); reset8 = 1'b1;
      wait_to(266); check("w8_async", q8, RV8);
      wait_to(271); check("w8_rst_edge", q8, RV8);
      wait_to(285); reset8 = 1'b0;

      // Randomized cycles: reference is "last d seen at an edge with reset low, else reset value".
      for (int k = 0; k < 60; k++) begin
         t0 = 64'd285 + 64'd20 * longint'(k);
         wait_to(t0);
         r8 = 8'($urandom);
         r1 = 1'($urandom);
         d8 = r8;
         d1 = r1;
         if ($urandom_range(0, 5) == 0) begin
            reset8 = 1'b1; reset1 = 1'b1;
            exp8 = RV8; exp1 = 1'b0;
            wait_to(t0 + 1);
            check("rnd_async_w8", q8, exp8);
            check("rnd_async_w1", {7'd0, q1}, {7'd0, exp1});
            wait_to(t0 + 15);
            check("rnd_rst_edge_w8", q8, exp8);
            reset8 = 1'b0; reset1 = 1'b0;
         end else begin
            wait_to(t0 + 6);
            exp8 = r8; exp1 = r1;
            check("rnd_cap_w8", q8, exp8);
            check("rnd_cap_w1", {7'd0, q1}, {7'd0, exp1});
            wait_to(t0 + 10);
            d8 = ~r8; d1 = ~r1;
            wait_to(t0 + 13);
            d8 = r8; d1 = r1;
            wait_to(t0 + 15);
            check("rnd_hold_w8", q8, exp8);
            check("rnd_hold_w1", {7'd0, q1}, {7'd0, exp1});
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
